encoder_32x5_scan: RTL and testbench

ENCODER_32X5_SCAN -- requirements
Module: encoder_32x5_scan

---
 rtl/encoder_pkg.sv | 6 +
 rtl/encoder_32x5_scan_priority_enc32.sv | 14 +
 rtl/encoder_32x5_scan.sv | 71 +++++++
 tb/tb_encoder_32x5_scan.sv | 126 ++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared sizes and scan state encoding for encoder_32x5_scan.
package encoder_pkg;
   localparam int N     = 32;
   localparam int IDX_W = 5;
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;
endpackage

// File: rtl/encoder_32x5_scan_priority_enc32.sv
// priority_enc32: index of the lowest set bit of a 32-bit vector, plus an any-set flag.
module priority_enc32 (
   input  logic [encoder_pkg::N-1:0]     vec_i,
   output logic [encoder_pkg::IDX_W-1:0] idx_o,
   output logic                          any_o
);
   import encoder_pkg::*;
   assign any_o = |vec_i;
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--)
         if (vec_i[i]) idx_o = i[IDX_W-1:0];
   end
endmodule

// File: rtl/encoder_32x5_scan.sv
// encoder_32x5_scan: streams indices of the set bits of a loaded vector, lowest first.
// Define ENCODER_ZERO_ERR_EN to flag zero-vector loads on err.
module encoder_32x5_scan #(
   parameter int N     = encoder_pkg::N,
   parameter int IDX_W = encoder_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     load_vec,
   input  logic             load_valid,
   output logic             load_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             done,
   output logic             err
);
   import encoder_pkg::*;
   state_e           state_q, state_d;
   logic [N-1:0]     pend_q, pend_d, pend_clr;
   logic             done_q, done_d, enc_any, load_acc, xfer;
   logic [IDX_W-1:0] enc_idx;

   priority_enc32 u_enc (.vec_i(pend_q), .idx_o(enc_idx), .any_o(enc_any));

   assign load_ready = state_q == IDLE;
   assign out_valid  = state_q == SCAN && enc_any;
   assign out_idx    = out_valid ? enc_idx : '0;
   assign done       = done_q;
   assign load_acc   = load_valid && load_ready;
   assign xfer       = out_valid && out_ready;
   assign pend_clr   = pend_q & ~(N'(1) << enc_idx);

   // A load or the final transfer that leaves nothing pending ends the vector.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      if (load_acc) begin
         pend_d  = load_vec;
         state_d = |load_vec ? SCAN : IDLE;
         done_d  = ~|load_vec;
      end else if (xfer) begin
         pend_d  = pend_clr;
         state_d = |pend_clr ? SCAN : IDLE;
         done_d  = ~|pend_clr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
      end
   end

`ifdef ENCODER_ZERO_ERR_EN
   logic err_q;
   always_ff @(posedge clk) begin
      err_q <= rst ? 1'b0 : load_acc && ~|load_vec;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_encoder_32x5_scan.sv
// tb_encoder_32x5_scan: directed vectors with hand-computed expected indices and handshakes.
module tb_encoder_32x5_scan;
   logic        clk = 1'b0;
   logic        rst, load_valid, load_ready, out_valid, out_ready, done, err;
   logic [31:0] load_vec;
   logic [4:0]  out_idx;
   int          checks = 0, errors = 0;
   logic        err_exp;

   encoder_32x5_scan dut (
      .clk(clk), .rst(rst), .load_vec(load_vec), .load_valid(load_valid),
      .load_ready(load_ready), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [31:0] v);
      load_vec   = v;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [4:0] idx, input logic d, input logic lr);
      check({tag, "_valid"}, 32'(out_valid), 32'(v));
      check({tag, "_idx"}, 32'(out_idx), 32'(idx));
      check({tag, "_done"}, 32'(done), 32'(d));
      check({tag, "_ready"}, 32'(load_ready), 32'(lr));
   endtask

   initial begin
`ifdef ENCODER_ZERO_ERR_EN
      err_exp = 1'b1;
`else
      err_exp = 1'b0;
`endif
      rst = 1'b1; load_valid = 1'b0; load_vec = '0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk_out("rst", 1'b0, 5'd0, 1'b0, 1'b1);
      check("rst_err", 32'(err), 32'd0);

      load(32'h0000_0001);
      chk_out("one_t1", 1'b1, 5'd0, 1'b0, 1'b0);
      tick();
      chk_out("one_t2", 1'b0, 5'd0, 1'b1, 1'b1);
      check("one_err", 32'(err), 32'd0);
      tick();
      chk_out("one_t3", 1'b0, 5'd0, 1'b0, 1'b1);

      load(32'h8000_0005);
      chk_out("hi_a", 1'b1, 5'd0, 1'b0, 1'b0);
      tick();
      chk_out("hi_b", 1'b1, 5'd2, 1'b0, 1'b0);
      tick();
      chk_out("hi_c", 1'b1, 5'd31, 1'b0, 1'b0);
      tick();
      chk_out("hi_done", 1'b0, 5'd0, 1'b1, 1'b1);

      out_ready = 1'b0;
      load(32'h0000_0110);
      for (int i = 0; i < 3; i++) begin
         chk_out("stall", 1'b1, 5'd4, 1'b0, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      chk_out("rel_a", 1'b1, 5'd4, 1'b0, 1'b0);
      tick();
      chk_out("rel_b", 1'b1, 5'd8, 1'b0, 1'b0);
      tick();
      chk_out("rel_done", 1'b0, 5'd0, 1'b1, 1'b1);
      tick();

      load(32'h0000_0000);
      chk_out("zero", 1'b0, 5'd0, 1'b1, 1'b1);
      check("zero_err", 32'(err), 32'(err_exp));
      tick();
      chk_out("zero_after", 1'b0, 5'd0, 1'b0, 1'b1);
      check("zero_err_after", 32'(err), 32'd0);

      load(32'hFFFF_FFFF);
      chk_out("ff_a", 1'b1, 5'd0, 1'b0, 1'b0);
      tick();
      chk_out("ff_b", 1'b1, 5'd1, 1'b0, 1'b0);
      tick();
      chk_out("ff_c", 1'b1, 5'd2, 1'b0, 1'b0);
      tick();
      chk_out("ff_d", 1'b1, 5'd3, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("abort", 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
      chk_out("abort_after", 1'b0, 5'd0, 1'b0, 1'b1);

      load_vec = 32'h0000_0003;
      load_valid = 1'b1;
      tick();
      load_vec = 32'h0000_00F0;
      chk_out("ign_a", 1'b1, 5'd0, 1'b0, 1'b0);
      tick();
      chk_out("ign_b", 1'b1, 5'd1, 1'b0, 1'b0);
      tick();
      chk_out("ign_done", 1'b0, 5'd0, 1'b1, 1'b1);
      load_valid = 1'b0;
      tick();
      chk_out("ign_idle", 1'b0, 5'd0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
